// File: rtl/vga_timing_sequencer.sv
// Raster scheduler for the VGA controller: coordinated horizontal/vertical phase FSMs
// driving registered sync, display enable, pixel coordinates and line/frame strobes.
module vga_timing_sequencer #(
    parameter int unsigned COUNTER_SIZE = 11,
    parameter int unsigned H_ACTIVE     = 640,
    parameter int unsigned H_FP         = 16,
    parameter int unsigned H_SYNC       = 96,
    parameter int unsigned H_BP         = 48,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned V_FP         = 10,
    parameter int unsigned V_SYNC       = 2,
    parameter int unsigned V_BP         = 33,
    parameter bit          H_SYNC_POL   = 1'b0,
    parameter bit          V_SYNC_POL   = 1'b0
) (
    input  logic                    control_clock,
    input  logic                    reset,
    input  logic                    pixel_tick,
    output logic [COUNTER_SIZE-1:0] h_count,
    output logic [COUNTER_SIZE-1:0] v_count,
    output logic                    hsync,
    output logic                    vsync,
    output logic                    display_enable,
    output logic                    line_start,
    output logic                    frame_start
);

    localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
    localparam int unsigned H_BACK_START = H_SYNC_START + H_SYNC;
    localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
    localparam int unsigned V_BACK_START = V_SYNC_START + V_SYNC;

    localparam logic [COUNTER_SIZE-1:0] H_LAST = COUNTER_SIZE'(H_TOTAL - 1);
    localparam logic [COUNTER_SIZE-1:0] V_LAST = COUNTER_SIZE'(V_TOTAL - 1);
    localparam logic [COUNTER_SIZE-1:0] ONE    = COUNTER_SIZE'(1);

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FRONT,
        PH_SYNC,
        PH_BACK
    } phase_e;

    logic [COUNTER_SIZE-1:0] h_count_q, h_count_d;
    logic [COUNTER_SIZE-1:0] v_count_q, v_count_d;
    phase_e                  h_state_q, h_state_d;
    phase_e                  v_state_q, v_state_d;
    logic                    hsync_q, hsync_d;
    logic                    vsync_q, vsync_d;
    logic                    de_q, de_d;
    logic                    line_start_q, line_start_d;
    logic                    frame_start_q, frame_start_d;
    logic                    h_wrap, v_wrap;

    // Phase that the axis enters given its next count; zero-length phases are
    // skipped because their start coincides with the following phase's start.
    function automatic phase_e next_phase(
        input phase_e      cur,
        input int unsigned nxt,
        input logic        wrap,
        input int unsigned fp_start,
        input int unsigned sync_start,
        input int unsigned bp_start,
        input int unsigned fp_len,
        input int unsigned sync_len
    );
        phase_e n;
        n = cur;
        if (wrap) begin
            n = PH_ACTIVE;
        end else begin
            case (cur)
                PH_ACTIVE: if (nxt == fp_start)
                    n = (fp_len != 0) ? PH_FRONT : ((sync_len != 0) ? PH_SYNC : PH_BACK);
                PH_FRONT:  if (nxt == sync_start)
                    n = (sync_len != 0) ? PH_SYNC : PH_BACK;
                PH_SYNC:   if (nxt == bp_start)
                    n = PH_BACK;
                default:   n = cur;
            endcase
        end
        return n;
    endfunction

    always_ff @(posedge control_clock) begin
        if (reset) begin
            h_count_q     <= '0;
            v_count_q     <= '0;
            h_state_q     <= PH_ACTIVE;
            v_state_q     <= PH_ACTIVE;
            hsync_q       <= ~H_SYNC_POL;
            vsync_q       <= ~V_SYNC_POL;
            de_q          <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_count_q     <= h_count_d;
            v_count_q     <= v_count_d;
            h_state_q     <= h_state_d;
            v_state_q     <= v_state_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    always_comb begin
        h_wrap    = pixel_tick && (h_count_q == H_LAST);
        v_wrap    = h_wrap && (v_count_q == V_LAST);
        h_count_d = h_count_q;
        v_count_d = v_count_q;
        h_state_d = h_state_q;
        v_state_d = v_state_q;
        if (pixel_tick) begin
            h_count_d = h_wrap ? '0 : h_count_q + ONE;
            h_state_d = next_phase(h_state_q, 32'(h_count_d), h_wrap,
                                   H_ACTIVE, H_SYNC_START, H_BACK_START, H_FP, H_SYNC);
        end
        if (h_wrap) begin
            v_count_d = v_wrap ? '0 : v_count_q + ONE;
            v_state_d = next_phase(v_state_q, 32'(v_count_d), v_wrap,
                                   V_ACTIVE, V_SYNC_START, V_BACK_START, V_FP, V_SYNC);
        end
    end

    // Outputs are decoded from the next phases so they land on the same edge as the counters.
    always_comb begin
        hsync_d       = (h_state_d == PH_SYNC) ? H_SYNC_POL : ~H_SYNC_POL;
        vsync_d       = (v_state_d == PH_SYNC) ? V_SYNC_POL : ~V_SYNC_POL;
        de_d          = (h_state_d == PH_ACTIVE) && (v_state_d == PH_ACTIVE);
        line_start_d  = h_wrap;
        frame_start_d = v_wrap;
    end

    assign h_count        = h_count_q;
    assign v_count        = v_count_q;
    assign hsync          = hsync_q;
    assign vsync          = vsync_q;
    assign display_enable = de_q;
    assign line_start     = line_start_q;
    assign frame_start    = frame_start_q;

endmodule

// File: tb/tb_vga_timing_sequencer.sv
// Scoreboard bench: a small-geometry instance (with zero-length porches) and a default
// 640x480 instance, both checked every cycle against a raster model plus tallied periods.
module tb_vga_timing_sequencer;

    localparam int unsigned CS    = 11;
    localparam int unsigned S_HA  = 8, S_HFP = 2, S_HS = 3, S_HBP = 0;
    localparam int unsigned S_VA  = 4, S_VFP = 0, S_VS = 2, S_VBP = 1;
    localparam int unsigned S_HT  = 13, S_VT = 7;
    localparam int unsigned D_HA  = 640, D_HFP = 16, D_HS = 96;
    localparam int unsigned D_VA  = 480, D_VFP = 10, D_VS = 2;
    localparam int unsigned D_HT  = 800, D_VT = 525;

    logic clk = 1'b0;
    logic rst, tick;
    always #5 clk = ~clk;

    logic [CS-1:0] s_h, s_v, d_h, d_v;
    logic s_hs, s_vs, s_de, s_ls, s_fs;
    logic d_hs, d_vs, d_de, d_ls, d_fs;

    vga_timing_sequencer #(
        .COUNTER_SIZE(CS),
        .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0)
    ) dut_s (
        .control_clock(clk), .reset(rst), .pixel_tick(tick),
        .h_count(s_h), .v_count(s_v), .hsync(s_hs), .vsync(s_vs),
        .display_enable(s_de), .line_start(s_ls), .frame_start(s_fs)
    );

    vga_timing_sequencer dut_d (
        .control_clock(clk), .reset(rst), .pixel_tick(tick),
        .h_count(d_h), .v_count(d_v), .hsync(d_hs), .vsync(d_vs),
        .display_enable(d_de), .line_start(d_ls), .frame_start(d_fs)
    );

    typedef struct packed {
        logic [7:0]  tag;
        logic [26:0] s;
        logic [26:0] d;
    } item_t;

    item_t q[$];
    int checks   = 0;
    int failures = 0;

    int unsigned mh_s = 0, mv_s = 0, mh_d = 0, mv_d = 0;
    logic mls_s = 1'b0, mfs_s = 1'b0, mls_d = 1'b0, mfs_d = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sync pulses are active-low in both instances.
    function automatic logic [26:0] expect_out(
        input int unsigned h, input int unsigned v,
        input int unsigned ha, input int unsigned hfp, input int unsigned hs,
        input int unsigned va, input int unsigned vfp, input int unsigned vs,
        input logic ls, input logic fs);
        logic de, hsy, vsy;
        de  = (h < ha) && (v < va);
        hsy = !((h >= ha + hfp) && (h < ha + hfp + hs));
        vsy = !((v >= va + vfp) && (v < va + vfp + vs));
        return {11'(h), 11'(v), hsy, vsy, de, ls, fs};
    endfunction

    task automatic step(input logic r, input logic t, input int tg);
        item_t it;
        @(negedge clk);
        rst  = r;
        tick = t;
        @(posedge clk);
        if (r) begin
            mh_s = 0; mv_s = 0; mh_d = 0; mv_d = 0;
            mls_s = 0; mfs_s = 0; mls_d = 0; mfs_d = 0;
        end else if (t) begin
            mls_s = (mh_s == S_HT - 1);
            mfs_s = mls_s && (mv_s == S_VT - 1);
            mh_s  = mls_s ? 0 : mh_s + 1;
            if (mls_s) mv_s = mfs_s ? 0 : mv_s + 1;
            mls_d = (mh_d == D_HT - 1);
            mfs_d = mls_d && (mv_d == D_VT - 1);
            mh_d  = mls_d ? 0 : mh_d + 1;
            if (mls_d) mv_d = mfs_d ? 0 : mv_d + 1;
        end else begin
            mls_s = 0; mfs_s = 0; mls_d = 0; mfs_d = 0;
        end
        it.tag = 8'(tg);
        it.s   = expect_out(mh_s, mv_s, S_HA, S_HFP, S_HS, S_VA, S_VFP, S_VS, mls_s, mfs_s);
        it.d   = expect_out(mh_d, mv_d, D_HA, D_HFP, D_HS, D_VA, D_VFP, D_VS, mls_d, mfs_d);
        q.push_back(it);
    endtask

    // Monitor: pops one expectation per cycle and keeps per-phase period tallies.
    initial begin
        item_t it;
        int cur_tag = -1, k = 0;
        int prev_sfs = -1, prev_sls = -1;
        int s_de_n = 0, s_hs_n = 0, s_vs_n = 0, d_de_n = 0, d_hs_n = 0;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                it = q.pop_front();
                chk("small_outputs", {s_h, s_v, s_hs, s_vs, s_de, s_ls, s_fs}, it.s);
                chk("default_outputs", {d_h, d_v, d_hs, d_vs, d_de, d_ls, d_fs}, it.d);
                if (int'(it.tag) != cur_tag) begin
                    cur_tag = int'(it.tag);
                    k = 0; prev_sfs = -1; prev_sls = -1;
                end
                k++;
                if (cur_tag == 2) begin
                    if (s_fs) begin
                        if (prev_sfs >= 0) chk("frame_period_small", k - prev_sfs, 91);
                        prev_sfs = k;
                    end
                    if (s_ls) begin
                        if (prev_sls >= 0) chk("line_period_small", k - prev_sls, 13);
                        prev_sls = k;
                    end
                    if (k <= 91) begin
                        s_de_n += int'(s_de); s_hs_n += int'(!s_hs); s_vs_n += int'(!s_vs);
                    end
                    if (k == 91) begin
                        chk("de_per_frame_small", s_de_n, 32);
                        chk("hsync_per_frame_small", s_hs_n, 21);
                        chk("vsync_per_frame_small", s_vs_n, 26);
                    end
                    if (k <= 800) begin
                        d_de_n += int'(d_de); d_hs_n += int'(!d_hs);
                    end
                    if (d_ls) chk("first_line_start_default", k, 800);
                    if (k == 800) begin
                        chk("de_per_line_default", d_de_n, 640);
                        chk("hsync_per_line_default", d_hs_n, 96);
                    end
                end else if (cur_tag == 3) begin
                    if (s_ls) begin
                        if (prev_sls >= 0) chk("line_period_alt_small", k - prev_sls, 26);
                        prev_sls = k;
                    end
                end else if (cur_tag == 5) begin
                    if (s_fs && prev_sfs < 0) begin
                        chk("frame_after_reset_small", k, 91);
                        prev_sfs = k;
                    end
                end
            end
        end
    end

    initial begin
        rst  = 1'b1;
        tick = 1'b1;
        repeat (3) step(1'b1, 1'b1, 1);
        repeat (900) step(1'b0, 1'b1, 2);
        repeat (200) begin
            step(1'b0, 1'b1, 3);
            step(1'b0, 1'b0, 3);
        end
        repeat (37) step(1'b0, 1'b1, 0);
        step(1'b1, 1'b1, 4);
        repeat (200) step(1'b0, 1'b1, 5);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
